mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter N, default 32, data/address width; only N=32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00=byte, 01=halfword, 10=word, 11=reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  N  byte address.
REQ-010 req_wdata  input  N  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  N  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid; misaligned address or reserved size.
REQ-014 mem_a  output  N  word memory address (memory indexes with bits [N-1:2]).
REQ-015 mem_we  output  1  word memory write enable.
REQ-016 mem_wd  output  N  word memory write data.
REQ-017 mem_rd  input  N  word memory read data, combinational from mem_a.

Function
REQ-018 The FSM states SHALL be IDLE, LOAD, RMW_RD, WRITE, RESP and ERR.
REQ-019 Handshake: a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; the unit SHALL latch we, size, unsigned, addr and wdata on that edge.
REQ-020 The FSM SHALL flag misalignment for halfwords with addr[0]=1, words with addr[1:0]!=00, and any request with size=11.
REQ-021 IDLE transitions: misaligned->ERR; load->LOAD; word store->WRITE; byte/half store->RMW_RD; no request->IDLE.
REQ-022 LOAD: mem_a={addr[N-1:2],2'b00}; mem_rd SHALL be captured, lane-selected and extended into the response register; next state RESP.
REQ-023 Byte lanes are little-endian: byte k=addr[1:0] occupies bits [8k+7:8k]; halfword at addr[1]=h occupies bits [16h+15:16h].
REQ-024 RMW_RD: mem_a=word address; a merge register SHALL capture mem_rd with the addressed lane(s) replaced by req_wdata[7:0] or [15:0]; next state WRITE.
REQ-025 WRITE: mem_a=word address, mem_we=1, mem_wd=merge register (sub-word) or latched wdata (word); next state RESP.
REQ-026 RESP: resp_valid=1, resp_err=0, resp_rdata=load result or 0; next state IDLE.
REQ-027 ERR: resp_valid=1, resp_err=1, resp_rdata=0, mem_we=0, no memory access; next state IDLE.
REQ-028 Latency from the accept edge to resp_valid SHALL be 2 cycles for loads and word stores, 3 for sub-word stores and 1 for errors.
REQ-029 Throughput: a new request SHALL NOT be accepted until the unit has returned to IDLE; back-to-back requests are therefore spaced by the latency plus 1 cycle.
REQ-030 In states without a memory access, mem_a SHALL be 0 and mem_wd SHALL be 0.
REQ-031 mem_we SHALL be high only in WRITE, and SHALL be gated low in any cycle where reset=1.
REQ-032 req_valid asserted while req_ready=0 SHALL be ignored with no side effects.

Reset
REQ-033 On a rising edge with reset=1 the FSM SHALL enter IDLE and clear all latched request, merge and response registers to 0.
REQ-034 After reset, the outputs SHALL be req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_a=0, mem_we=0 and mem_wd=0.
REQ-035 Reset asserted in any state, including WRITE, SHALL abort the operation with no memory write and no response.

Verification
REQ-036 Memory word 0x10=0x8899AABB, load byte signed at addr 0x12 -> resp_rdata=0xFFFFFF99 two cycles after accept; load byte unsigned -> 0x00000099.
REQ-037 The same word with a load half signed at 0x10 -> 0xFFFFAABB; load half unsigned at 0x12 -> 0x00008899.
REQ-038 Store byte 0x5A at 0x11 -> exactly one mem_we pulse with mem_wd=0x88995ABB, and resp_valid 3 cycles after accept; a subsequent word load returns 0x88995ABB.
REQ-039 Word store at 0x06, half store at 0x03 and size=11 -> resp_valid with resp_err=1 one cycle after accept, no mem_we pulse, and the memory unchanged.
REQ-040 Reset asserted during WRITE of a word store 0xDEADBEEF to 0x20 -> mem_we=0 that cycle, the memory word unchanged, no resp_valid, and req_ready=1 the cycle after.
REQ-041 req_valid held high continuously for four mixed requests -> each is accepted only in IDLE, the responses arrive in order with the REQ-028 latencies, and no request is dropped or duplicated.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word CPU requests into accesses on a
// single-port word memory, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] mem_a,
  output logic         mem_we,
  output logic [N-1:0] mem_wd,
  input  logic [N-1:0] mem_rd,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t       state;
  logic         we_q;
  logic [1:0]   size_q;
  logic         uns_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] merge_q;
  logic [N-1:0] rdata_q;

  logic         misaligned;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [N-1:0] load_val;
  logic [N-1:0] merge_val;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only while idle.
  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    byte_sel  = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = mem_rd[{addr_q[1], 4'b0000} +: 16];
    load_val  = mem_rd;
    merge_val = mem_rd;
    case (size_q)
      SZ_BYTE: begin
        load_val = uns_q ? {{(N-8){1'b0}}, byte_sel} : {{(N-8){byte_sel[7]}}, byte_sel};
        merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = uns_q ? {{(N-16){1'b0}}, half_sel} : {{(N-16){half_sel[15]}}, half_sel};
        merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            merge_q <= '0;
            rdata_q <= '0;
            if (misaligned)             state <= ERR;
            else if (!req_we)           state <= LOAD;
            else if (req_size == SZ_WORD) state <= WRITE;
            else                        state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata_q <= load_val;
          state   <= RESP;
        end
        RMW_RD: begin
          merge_q <= merge_val;
          state   <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register; mem_we is additionally
  // gated by reset so an aborted WRITE never reaches memory.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP) || (state == ERR);
    resp_err   = (state == ERR);
    resp_rdata = (state == RESP) ? rdata_q : '0;
    mem_a      = (state == LOAD || state == RMW_RD || state == WRITE) ?
                 {addr_q[N-1:2], 2'b00} : '0;
    mem_we     = (state == WRITE) && !reset;
    mem_wd     = (state == WRITE) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : '0;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized requests checked
// against an arithmetic reference of the load/store rules and a shadow memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  mem_access_unit #(.N(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .state_dbg(state_dbg)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int          we_pulses = 0;
  logic [31:0] last_wd;
  logic [31:0] last_rdata;
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chain_ok = 0;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
      last_wd         <= mem_wd;
      we_pulses       <= we_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: misalignment, lane extraction/extension and lane merge by
  // shift-and-mask arithmetic on the shadow memory.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata, output int lat);
    int          width;
    int          sh;
    int          idx;
    logic [31:0] mask;
    logic [31:0] w;
    logic [31:0] v;
    err   = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    rdata = 0;
    lat   = 1;
    if (!err) begin
      width = (size == 0) ? 8 : (size == 1) ? 16 : 32;
      mask  = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      sh    = 8 * int'(addr % 4);
      idx   = int'(addr / 4) % 64;
      w     = ref_mem[idx];
      if (!we) begin
        v = (w >> sh) & mask;
        if (!uns && width < 32 && v[width-1]) v = v | ~mask;
        rdata = v;
        lat   = 2;
      end else begin
        ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        lat          = (width == 32) ? 2 : 3;
      end
    end
  endtask

  // Called at a falling edge; leaves on the falling edge where the response
  // is visible, so consecutive calls exercise back-to-back spacing.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          waits;
    int          lat;
    int          p0;
    bit          rdy;
    bit          acc;
    bit          seen;
    model(we, size, uns, addr, wdata, exp_err, exp_rd, exp_lat);
    exp_q.push_back(exp_rd);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    acc = 0; waits = 0;
    for (int i = 0; i < 12 && !acc; i++) begin
      rdy = req_ready;
      @(posedge clk);
      waits++;
      if (rdy) acc = 1;
      else @(negedge clk);
    end
    check("accept", 32'(acc), 32'd1);
    if (chain_ok) check("spacing", 32'(waits), 32'd2);
    #1;
    if (!keep) req_valid = 0;
    p0 = we_pulses;
    seen = 0; lat = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) seen = 1;
      else check("busy_ready", 32'(req_ready), 32'd0);
    end
    check("resp_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_q.pop_front());
    check("we_pulses", 32'(we_pulses - p0), 32'((we && !exp_err) ? 1 : 0));
    last_rdata = resp_rdata;
    chain_ok = acc;
  endtask

  task automatic rand_req(input bit keep);
    logic [1:0]  sz;
    logic [31:0] a;
    sz = 2'($urandom_range(0, 3));
    a  = $urandom_range(0, 255);
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
    end
    do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, keep);
  endtask

  initial begin
    logic [2:0] idle_code;
    int         p0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;
    reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    idle_code = state_dbg;
    reset = 0;
    @(negedge clk);

    do_req(0, 2'b00, 0, 32'h12, 32'h0, 0);
    check("lb_signed", last_rdata, 32'hFFFF_FF99);
    do_req(0, 2'b00, 1, 32'h12, 32'h0, 0);
    check("lb_unsigned", last_rdata, 32'h0000_0099);
    do_req(0, 2'b01, 0, 32'h10, 32'h0, 0);
    check("lh_signed", last_rdata, 32'hFFFF_AABB);
    do_req(0, 2'b01, 1, 32'h12, 32'h0, 0);
    check("lh_unsigned", last_rdata, 32'h0000_8899);
    do_req(1, 2'b00, 0, 32'h11, 32'h1234_565A, 0);
    check("sb_wd", last_wd, 32'h8899_5ABB);
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
    check("lw_after_sb", last_rdata, 32'h8899_5ABB);
    do_req(1, 2'b10, 0, 32'h06, 32'hFFFF_FFFF, 0);
    do_req(1, 2'b01, 0, 32'h03, 32'hFFFF_FFFF, 0);
    do_req(1, 2'b11, 0, 32'h10, 32'hFFFF_FFFF, 0);
    @(posedge clk); @(negedge clk);
    check("idle_mem_a", mem_a, 32'd0);
    check("idle_mem_wd", mem_wd, 32'd0);

    // Abort a word store while it sits in WRITE.
    p0 = we_pulses;
    req_valid = 1; req_we = 1; req_size = 2'b10; req_unsigned = 0;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    check("busy_state", 32'(state_dbg != idle_code), 32'd1);
    reset = 1;
    #1 check("abort_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 0;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", 32'(resp_valid), 32'd0);
    end
    check("abort_no_write", 32'(we_pulses - p0), 32'd0);
    chain_ok = 0;
    do_req(0, 2'b10, 0, 32'h20, 32'h0, 0);

    for (int i = 0; i < 150; i++) rand_req(1'($urandom_range(0, 1)));

    // Four mixed requests with req_valid never dropping.
    do_req(0, 2'b00, 0, 32'h41, 32'h0, 1);
    do_req(1, 2'b01, 0, 32'h46, 32'hCAFE_1234, 1);
    do_req(1, 2'b10, 0, 32'h45, 32'h0, 1);
    do_req(1, 2'b10, 0, 32'h44, 32'hA5A5_5A5A, 1);
    do_req(0, 2'b01, 1, 32'h46, 32'h0, 0);

    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
